adda_wavegen: RTL and testbench



---
 rtl/adda_wavegen.sv | 278 +++++++++++++++++++++++++++
 tb/tb_adda_wavegen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adda_wavegen.sv
// adda_wavegen: programmable DA test-pattern generator (ramp up/down, triangle, square).
// Define ADDA_LOOPBACK_CHECK_EN to add the AD-return loopback checker (ad_data, lb_err_cnt).
module adda_wavegen #(
  parameter int DW     = 8,
  parameter int DIV_W  = 16,
  parameter int LB_LAT = 3,
  parameter int LB_TOL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_mode,
  input  logic [DW-1:0]    cfg_lo,
  input  logic [DW-1:0]    cfg_hi,
  input  logic [DW-1:0]    cfg_step,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             cfg_err,
  output logic [DW-1:0]    da_data,
  output logic             da_upd,
`ifdef ADDA_LOOPBACK_CHECK_EN
  output logic             wrap_pulse,
  input  logic [DW-1:0]    ad_data,
  output logic [15:0]      lb_err_cnt
`else
  output logic             wrap_pulse
`endif
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STOP_PEND = 2'd2;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_SQR  = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             busy_r;
  logic             cfg_err_r;
  logic [1:0]       mode_r;
  logic [DW-1:0]    lo_r;
  logic [DW-1:0]    hi_r;
  logic [DW-1:0]    step_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] presc_r;
  logic             dir_down_r;
  logic [DW-1:0]    da_r;
  logic             da_upd_r;
  logic             wrap_r;

  logic             start_ok_s;
  logic             start_bad_s;
  logic             tick_s;
  logic [DW:0]      sum_s;
  logic [DW:0]      lo_step_s;
  logic [DW-1:0]    nxt_code_s;
  logic             nxt_wrap_s;
  logic             nxt_dir_down_s;

  assign start_ok_s  = (state_r == ST_IDLE) && start && (cfg_lo < cfg_hi);
  assign start_bad_s = (state_r == ST_IDLE) && start && !(cfg_lo < cfg_hi);
  assign tick_s      = busy_r && (presc_r == div_r);
  // Sums are one bit wider than the code so bound comparisons never alias.
  assign sum_s       = {1'b0, da_r} + {1'b0, step_r};
  assign lo_step_s   = {1'b0, lo_r} + {1'b0, step_r};

  assign busy       = busy_r;
  assign cfg_err    = cfg_err_r;
  assign da_data    = da_r;
  assign da_upd     = da_upd_r;
  assign wrap_pulse = wrap_r;

  // Next waveform code, wrap marker and triangle direction for the coming tick.
  always_comb begin
    nxt_code_s     = da_r;
    nxt_wrap_s     = 1'b0;
    nxt_dir_down_s = dir_down_r;
    case (mode_r)
      MODE_UP: begin
        if (sum_s > {1'b0, hi_r}) begin
          nxt_code_s = lo_r;
          nxt_wrap_s = 1'b1;
        end else begin
          nxt_code_s = sum_s[DW-1:0];
        end
      end
      MODE_DOWN: begin
        if ({1'b0, da_r} < lo_step_s) begin
          nxt_code_s = hi_r;
          nxt_wrap_s = 1'b1;
        end else begin
          nxt_code_s = da_r - step_r;
        end
      end
      MODE_TRI: begin
        if (!dir_down_r) begin
          if (sum_s >= {1'b0, hi_r}) begin
            nxt_code_s     = hi_r;
            nxt_dir_down_s = 1'b1;
          end else begin
            nxt_code_s = sum_s[DW-1:0];
          end
        end else begin
          if ({1'b0, da_r} <= lo_step_s) begin
            nxt_code_s     = lo_r;
            nxt_dir_down_s = 1'b0;
            nxt_wrap_s     = 1'b1;
          end else begin
            nxt_code_s = da_r - step_r;
          end
        end
      end
      MODE_SQR: begin
        if (da_r == lo_r) begin
          nxt_code_s = hi_r;
        end else begin
          nxt_code_s = lo_r;
          nxt_wrap_s = 1'b1;
        end
      end
      default: begin
        nxt_code_s = da_r;
      end
    endcase
  end

  // Control FSM next state; a pending stop completes on the wrap tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_nxt_s = ST_STOP_PEND;
        else      state_nxt_s = ST_RUN;
      end
      ST_STOP_PEND: begin
        if (tick_s && nxt_wrap_s) state_nxt_s = ST_IDLE;
        else                      state_nxt_s = ST_STOP_PEND;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register with busy and cfg_err registered alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      cfg_err_r <= start_bad_s;
    end
  end

  // Configuration snapshot taken only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 2'd0;
      lo_r   <= {DW{1'b0}};
      hi_r   <= {DW{1'b0}};
      step_r <= {{(DW-1){1'b0}}, 1'b1};
      div_r  <= {DIV_W{1'b0}};
    end else if (start_ok_s) begin
      mode_r <= cfg_mode;
      lo_r   <= cfg_lo;
      hi_r   <= cfg_hi;
      step_r <= (cfg_step == {DW{1'b0}}) ? {{(DW-1){1'b0}}, 1'b1} : cfg_step;
      div_r  <= cfg_div;
    end else begin
      mode_r <= mode_r;
      lo_r   <= lo_r;
      hi_r   <= hi_r;
      step_r <= step_r;
      div_r  <= div_r;
    end
  end

  // Update-rate prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {DIV_W{1'b0}};
    end else if (start_ok_s || tick_s) begin
      presc_r <= {DIV_W{1'b0}};
    end else if (busy_r) begin
      presc_r <= presc_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      presc_r <= presc_r;
    end
  end

  // DA code register with its update and wrap strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_r       <= {DW{1'b0}};
      da_upd_r   <= 1'b0;
      wrap_r     <= 1'b0;
      dir_down_r <= 1'b0;
    end else if (start_ok_s) begin
      da_r       <= (cfg_mode == MODE_DOWN) ? cfg_hi : cfg_lo;
      da_upd_r   <= 1'b1;
      wrap_r     <= 1'b0;
      dir_down_r <= 1'b0;
    end else if (tick_s) begin
      da_r       <= nxt_code_s;
      da_upd_r   <= 1'b1;
      wrap_r     <= nxt_wrap_s;
      dir_down_r <= nxt_dir_down_s;
    end else begin
      da_r       <= da_r;
      da_upd_r   <= 1'b0;
      wrap_r     <= 1'b0;
      dir_down_r <= dir_down_r;
    end
  end

`ifdef ADDA_LOOPBACK_CHECK_EN
  localparam int             FILL_W    = $clog2(LB_LAT + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LB_LAT);
  localparam logic [DW:0]    TOL_V     = (DW+1)'(LB_TOL);

  logic [DW-1:0]     lb_pipe_r [LB_LAT];
  logic [FILL_W-1:0] lb_fill_r;
  logic [15:0]       lb_cnt_r;
  logic [DW:0]       lb_diff_s;
  logic              lb_mis_s;

  assign lb_err_cnt = lb_cnt_r;

  // Absolute error between the AD return and the delayed DA code.
  always_comb begin
    if (ad_data >= lb_pipe_r[LB_LAT-1]) begin
      lb_diff_s = {1'b0, ad_data} - {1'b0, lb_pipe_r[LB_LAT-1]};
    end else begin
      lb_diff_s = {1'b0, lb_pipe_r[LB_LAT-1]} - {1'b0, ad_data};
    end
  end

  assign lb_mis_s = busy_r && (lb_fill_r == FILL_FULL) && (lb_diff_s > TOL_V);

  // DA delay line matching the AD return latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LB_LAT; i++) lb_pipe_r[i] <= {DW{1'b0}};
    end else begin
      for (int i = LB_LAT - 1; i > 0; i--) lb_pipe_r[i] <= lb_pipe_r[i-1];
      lb_pipe_r[0] <= da_r;
    end
  end

  // Fill tracking and saturating mismatch counter, both restarted by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_fill_r <= {FILL_W{1'b0}};
      lb_cnt_r  <= 16'h0000;
    end else if (start_ok_s) begin
      lb_fill_r <= {FILL_W{1'b0}};
      lb_cnt_r  <= 16'h0000;
    end else begin
      if (busy_r && (lb_fill_r != FILL_FULL)) lb_fill_r <= lb_fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
      else                                   lb_fill_r <= lb_fill_r;
      if (lb_mis_s && (lb_cnt_r != 16'hFFFF)) lb_cnt_r <= lb_cnt_r + 16'h0001;
      else                                   lb_cnt_r <= lb_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_adda_wavegen.sv
// Directed self-checking bench for adda_wavegen; inputs driven and outputs sampled on negedge.
module tb_adda_wavegen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_lo;
  logic [7:0]  cfg_hi;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_div;
  logic        start;
  logic        stop;
  logic        busy;
  logic        cfg_err;
  logic [7:0]  da_data;
  logic        da_upd;
  logic        wrap_pulse;
`ifdef ADDA_LOOPBACK_CHECK_EN
  logic [7:0]  ad_data;
  logic [15:0] lb_err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  adda_wavegen #(.DW(8), .DIV_W(16), .LB_LAT(3), .LB_TOL(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .cfg_step(cfg_step), .cfg_div(cfg_div), .start(start), .stop(stop), .busy(busy),
    .cfg_err(cfg_err), .da_data(da_data), .da_upd(da_upd),
`ifdef ADDA_LOOPBACK_CHECK_EN
    .wrap_pulse(wrap_pulse), .ad_data(ad_data), .lb_err_cnt(lb_err_cnt)
`else
    .wrap_pulse(wrap_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] st, input logic [15:0] dv);
    cfg_mode = m; cfg_lo = lo; cfg_hi = hi; cfg_step = st; cfg_div = dv;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(2'd0, 8'd0, 8'd0, 8'd0, 16'd0);
    repeat (2) @(negedge clk);
    n_vec++; if (da_data !== 8'd0) begin n_err++; $display("FAIL reset_da got %0d exp 0", da_data); end
    n_vec++; if ({busy, cfg_err, da_upd, wrap_pulse} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b exp 0000", {busy, cfg_err, da_upd, wrap_pulse}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_ramp();
    logic [7:0] exp_da;
    int wraps;
    apply_reset();
    set_cfg(2'd0, 8'd0, 8'd255, 8'd1, 16'd0);
    pulse_start();
    wraps = 0;
    n_vec++; if (da_data !== 8'd0 || busy !== 1'b1 || da_upd !== 1'b1) begin
      n_err++; $display("FAIL ramp_start da=%0d busy=%b upd=%b exp 0/1/1", da_data, busy, da_upd); end
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      exp_da = 8'(i);
      if (wrap_pulse === 1'b1) wraps++;
      n_vec++; if (da_data !== exp_da || da_upd !== 1'b1) begin
        n_err++; $display("FAIL ramp_da step %0d got %0d upd=%b exp %0d upd=1", i, da_data, da_upd, exp_da); end
      n_vec++; if (wrap_pulse !== (i == 256)) begin
        n_err++; $display("FAIL ramp_wrap step %0d got %b exp %b", i, wrap_pulse, (i == 256)); end
    end
    n_vec++; if (wraps !== 1) begin n_err++; $display("FAIL ramp_wrap_count got %0d exp 1", wraps); end
  endtask

  task automatic test_triangle();
    int seq [6] = '{14, 18, 20, 16, 12, 10};
    logic [7:0] prev;
    apply_reset();
    set_cfg(2'd2, 8'd10, 8'd20, 8'd4, 16'd2);
    pulse_start();
    n_vec++; if (da_data !== 8'd10) begin n_err++; $display("FAIL tri_start got %0d exp 10", da_data); end
    prev = 8'd10;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (c < 2) begin
          n_vec++; if (da_data !== prev || da_upd !== 1'b0 || wrap_pulse !== 1'b0) begin
            n_err++; $display("FAIL tri_hold k=%0d c=%0d da=%0d upd=%b wrap=%b exp %0d/0/0",
                              k, c, da_data, da_upd, wrap_pulse, prev); end
        end else begin
          n_vec++; if (da_data !== 8'(seq[k]) || da_upd !== 1'b1 || wrap_pulse !== (k == 5)) begin
            n_err++; $display("FAIL tri_tick k=%0d da=%0d upd=%b wrap=%b exp %0d/1/%b",
                              k, da_data, da_upd, wrap_pulse, seq[k], (k == 5)); end
        end
      end
      prev = 8'(seq[k]);
    end
  endtask

  task automatic test_graceful_stop();
    apply_reset();
    set_cfg(2'd1, 8'd0, 8'd9, 8'd3, 16'd0);
    pulse_start();
    n_vec++; if (da_data !== 8'd9 || busy !== 1'b1) begin
      n_err++; $display("FAIL stop_start da=%0d busy=%b exp 9/1", da_data, busy); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd6) begin n_err++; $display("FAIL stop_code6 got %0d exp 6", da_data); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_vec++; if (da_data !== 8'd3 || busy !== 1'b1 || wrap_pulse !== 1'b0) begin
      n_err++; $display("FAIL stop_code3 da=%0d busy=%b wrap=%b exp 3/1/0", da_data, busy, wrap_pulse); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd0 || busy !== 1'b1 || wrap_pulse !== 1'b0) begin
      n_err++; $display("FAIL stop_code0 da=%0d busy=%b wrap=%b exp 0/1/0", da_data, busy, wrap_pulse); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd9 || wrap_pulse !== 1'b1 || da_upd !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL stop_wrap da=%0d wrap=%b upd=%b busy=%b exp 9/1/1/0",
                        da_data, wrap_pulse, da_upd, busy); end
    repeat (3) @(negedge clk);
    n_vec++; if (da_data !== 8'd9 || busy !== 1'b0 || da_upd !== 1'b0 || wrap_pulse !== 1'b0) begin
      n_err++; $display("FAIL stop_hold da=%0d busy=%b upd=%b wrap=%b exp 9/0/0/0",
                        da_data, busy, da_upd, wrap_pulse); end
  endtask

  task automatic test_bad_config();
    set_cfg(2'd0, 8'd50, 8'd50, 8'd1, 16'd0);
    pulse_start();
    n_vec++; if (cfg_err !== 1'b1 || busy !== 1'b0 || da_data !== 8'd9 || da_upd !== 1'b0) begin
      n_err++; $display("FAIL badcfg_pulse err=%b busy=%b da=%0d upd=%b exp 1/0/9/0",
                        cfg_err, busy, da_data, da_upd); end
    @(negedge clk);
    n_vec++; if (cfg_err !== 1'b0 || busy !== 1'b0 || da_data !== 8'd9) begin
      n_err++; $display("FAIL badcfg_after err=%b busy=%b da=%0d exp 0/0/9", cfg_err, busy, da_data); end
  endtask

  task automatic test_step_zero();
    apply_reset();
    set_cfg(2'd0, 8'd3, 8'd5, 8'd0, 16'd0);
    pulse_start();
    n_vec++; if (da_data !== 8'd3) begin n_err++; $display("FAIL step0_start got %0d exp 3", da_data); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd4) begin n_err++; $display("FAIL step0_a got %0d exp 4", da_data); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd5) begin n_err++; $display("FAIL step0_b got %0d exp 5", da_data); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd3 || wrap_pulse !== 1'b1) begin
      n_err++; $display("FAIL step0_wrap da=%0d wrap=%b exp 3/1", da_data, wrap_pulse); end
  endtask

  task automatic test_square_start_stop();
    apply_reset();
    set_cfg(2'd3, 8'd5, 8'd7, 8'd1, 16'd0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_vec++; if (da_data !== 8'd5 || busy !== 1'b1) begin
      n_err++; $display("FAIL sq_start da=%0d busy=%b exp 5/1", da_data, busy); end
    set_cfg(2'd0, 8'd0, 8'd100, 8'd9, 16'd3);
    pulse_start();
    n_vec++; if (da_data !== 8'd7 || wrap_pulse !== 1'b0 || cfg_err !== 1'b0) begin
      n_err++; $display("FAIL sq_hi da=%0d wrap=%b err=%b exp 7/0/0", da_data, wrap_pulse, cfg_err); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd5 || wrap_pulse !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL sq_lo da=%0d wrap=%b busy=%b exp 5/1/1", da_data, wrap_pulse, busy); end
    @(negedge clk);
    n_vec++; if (da_data !== 8'd7 || busy !== 1'b1) begin
      n_err++; $display("FAIL sq_hi2 da=%0d busy=%b exp 7/1", da_data, busy); end
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0;
    #1;
    n_vec++; if (da_data !== 8'd0 || busy !== 1'b0 || da_upd !== 1'b0 || wrap_pulse !== 1'b0) begin
      n_err++; $display("FAIL midrst_async da=%0d busy=%b upd=%b wrap=%b exp 0/0/0/0",
                        da_data, busy, da_upd, wrap_pulse); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (da_data !== 8'd0 || busy !== 1'b0 || da_upd !== 1'b0) begin
      n_err++; $display("FAIL midrst_idle da=%0d busy=%b upd=%b exp 0/0/0", da_data, busy, da_upd); end
  endtask

`ifdef ADDA_LOOPBACK_CHECK_EN
  task automatic test_loopback();
    logic [7:0] h [4];
    logic done;
    apply_reset();
    set_cfg(2'd0, 8'd0, 8'd100, 8'd1, 16'd0);
    for (int i = 0; i < 4; i++) h[i] = 8'd0;
    ad_data = 8'd0;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = da_data;
      ad_data = h[3] + (((k == 10) || (k == 20) || (k == 30) || (k == 40)) ? 8'd5 : 8'd0);
      @(negedge clk);
    end
    n_vec++; if (lb_err_cnt !== 16'd4) begin n_err++; $display("FAIL lb_count got %0d exp 4", lb_err_cnt); end
    stop = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = da_data;
      ad_data = h[3];
      @(negedge clk);
      stop = 1'b0;
      if (busy === 1'b0) done = 1'b1;
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL lb_stop_timeout busy=%b exp 0", busy); end
    n_vec++; if (lb_err_cnt !== 16'd4) begin n_err++; $display("FAIL lb_count_hold got %0d exp 4", lb_err_cnt); end
    pulse_start();
    n_vec++; if (lb_err_cnt !== 16'd0) begin n_err++; $display("FAIL lb_clear got %0d exp 0", lb_err_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef ADDA_LOOPBACK_CHECK_EN
    ad_data = 8'd0;
`endif
    test_reset();
    test_ramp();
    test_triangle();
    test_graceful_stop();
    test_bad_config();
    test_step_zero();
    test_square_start_stop();
    test_reset_mid_run();
`ifdef ADDA_LOOPBACK_CHECK_EN
    test_loopback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
